atm_db_scheduler: RTL
=====================

ATM_DB_SCHEDULER -- requirements
Module: atm_db_scheduler

Interface
REQ-001 Parameter terminals_num, default 4: number of ATM terminals sharing the account database.
REQ-002 Parameter card_width, default 3: card-number width.
REQ-003 Parameter balance_width, default 20: balance/value width.
REQ-004 Parameter users_num, default 7: valid cards are 0..users_num-1.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req  in  terminals_num  per-terminal transaction request; level, held until gnt.
REQ-008 req_card  in  terminals_num*card_width  per-terminal card number, slice i for terminal i.
REQ-009 req_op  in  terminals_num*2  per-terminal op: 00 deposit, 01 withdraw, 10 inquiry, 11 reserved.
REQ-010 req_value  in  terminals_num*balance_width  per-terminal amount.
REQ-011 gnt  out  terminals_num  one-hot, one-cycle pulse: request accepted, payload latched.
REQ-012 rsp_valid  out  terminals_num  one-hot, one-cycle pulse to the granted terminal.
REQ-013 rsp_balance  out  balance_width  resulting balance; valid with rsp_valid.
REQ-014 rsp_error  out  1  operation rejected; valid with rsp_valid.
REQ-015 db_rd_en, db_wr_en  out  1 each  database read/write strobes.
REQ-016 db_addr  out  card_width  database address, equal to latched card.
REQ-017 db_wdata  out  balance_width  write data.
REQ-018 db_rdata  in  balance_width  read data, valid the cycle after db_rd_en (synchronous RAM).

Function
REQ-019 FSM states IDLE, READ, CALC, RESP; one transaction in flight at a time.
REQ-020 IDLE: if any req bit set, pick winner round-robin starting at terminal (last_winner+1) mod terminals_num, latch card/op/value, pulse gnt, go READ.
REQ-021 Round-robin pointer updates only on grant; after reset, terminal 0 has highest priority.
REQ-022 READ: db_rd_en=1, db_addr=latched card; go CALC.
REQ-023 CALC: compute from db_rdata; if op is deposit/withdraw and not in error, db_wr_en=1, db_wdata=new balance, same cycle; go RESP.
REQ-024 RESP: rsp_valid pulse to winner with registered rsp_balance/rsp_error; go IDLE.
REQ-025 Fixed latency: gnt at cycle N, db_rd_en at N, db_wr_en at N+1, rsp_valid at N+2; next gnt earliest N+3.
REQ-026 Deposit: new = old + value; error and no write if sum exceeds 2^balance_width-1.
REQ-027 Withdraw: new = old - value; error and no write if value > old; value == old is legal, result 0.
REQ-028 Inquiry: no write, rsp_balance = old, rsp_error=0.
REQ-029 Reserved op: error, no write, rsp_balance = old.
REQ-030 Card >= users_num: db_rd_en and db_wr_en suppressed, same state timing, rsp_error=1, rsp_balance=0.
REQ-031 On error, rsp_balance = old balance (except REQ-030).
REQ-032 req still high after rsp_valid is a new request, arbitrated in IDLE.
REQ-033 Changes on req_* of non-granted terminals never affect the in-flight transaction.

Reset
REQ-034 rst asserted: state IDLE, pointer to terminal 0, gnt, rsp_valid, rsp_balance, rsp_error, db_rd_en, db_wr_en, db_addr, db_wdata all 0, immediately (asynchronous).
REQ-035 rst mid-transaction aborts it: no db write, no rsp_valid for that transaction.

Structure
REQ-036 Shared package atm_pkg holds op encoding enum, FSM state enum, default widths.
REQ-037 Round-robin selection lives in one sub-module rr_arbiter (req vector, pointer -> one-hot grant).

Verification
REQ-038 Card 2 balance 1000, terminal 1 deposit 250 -> gnt[1], write 1250 at N+1, rsp_valid[1] at N+2, rsp_balance 1250, error 0.
REQ-039 Card 3 balance 100, withdraw 101 -> no db_wr_en, rsp_error 1, rsp_balance 100; withdraw 100 -> balance 0, error 0.
REQ-040 All four terminals request simultaneously from reset -> grant order 0,1,2,3, each gnt 3 cycles apart.
REQ-041 Card 7 inquiry (users_num 7) -> no db_rd_en, rsp_error 1, rsp_balance 0.
REQ-042 Balance 0xFFFF0, deposit 0x20 -> rsp_error 1, no write, rsp_balance 0xFFFF0.
REQ-043 rst pulsed in CALC cycle -> no db_wr_en, no rsp_valid, all outputs 0, next grant to terminal 0.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM account-database scheduler.
// Holds the default widths, the terminal operation encoding and the
// scheduler FSM state encoding.
package atm_pkg;

    localparam int unsigned DefTerminalsNum = 4;
    localparam int unsigned DefCardWidth    = 3;
    localparam int unsigned DefBalanceWidth = 20;
    localparam int unsigned DefUsersNum     = 7;

    typedef enum logic [1:0] {
        OpDeposit  = 2'b00,
        OpWithdraw = 2'b01,
        OpInquiry  = 2'b10,
        OpReserved = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StCalc,
        StResp
    } state_e;

    // Width of an index into n items, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/atm_db_scheduler_if.sv
// Bundle of terminal-side and database-side signals of the scheduler.
//   req/req_card/req_op/req_value : per-terminal requests, slice i = terminal i
//   gnt/rsp_valid                 : one-hot per-terminal pulses
//   rsp_balance/rsp_error         : response payload, valid with rsp_valid
//   db_*                          : synchronous-RAM port (rdata one cycle after rd_en)
// slave  : scheduler side
// master : terminals plus database side
interface atm_db_scheduler_if #(
    parameter int unsigned terminals_num = atm_pkg::DefTerminalsNum,
    parameter int unsigned card_width    = atm_pkg::DefCardWidth,
    parameter int unsigned balance_width = atm_pkg::DefBalanceWidth
);
    logic [terminals_num-1:0]               req;
    logic [terminals_num*card_width-1:0]    req_card;
    logic [terminals_num*2-1:0]             req_op;
    logic [terminals_num*balance_width-1:0] req_value;
    logic [terminals_num-1:0]               gnt;
    logic [terminals_num-1:0]               rsp_valid;
    logic [balance_width-1:0]               rsp_balance;
    logic                                   rsp_error;
    logic                                   db_rd_en;
    logic                                   db_wr_en;
    logic [card_width-1:0]                  db_addr;
    logic [balance_width-1:0]               db_wdata;
    logic [balance_width-1:0]               db_rdata;

    modport slave (
        input  req, req_card, req_op, req_value, db_rdata,
        output gnt, rsp_valid, rsp_balance, rsp_error,
        output db_rd_en, db_wr_en, db_addr, db_wdata
    );

    modport master (
        output req, req_card, req_op, req_value, db_rdata,
        input  gnt, rsp_valid, rsp_balance, rsp_error,
        input  db_rd_en, db_wr_en, db_addr, db_wdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: scans req starting at index ptr and wrapping,
// returning the first set bit as a one-hot grant plus its index.
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : index of the granted bit
module rr_arbiter #(
    parameter int unsigned n     = 4,
    parameter int unsigned ptr_w = 2
) (
    input  logic [n-1:0]     req,
    input  logic [ptr_w-1:0] ptr,
    output logic [n-1:0]     gnt,
    output logic [ptr_w-1:0] gnt_idx
);

    logic             found;
    logic [ptr_w-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < n; k++) begin
            idx = ptr_w'((32'(ptr) + k) % n);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/atm_db_scheduler.sv
// Serialises transactions from several ATM terminals onto one account database.
// One transaction is in flight at a time: grant+read, calculate+write, respond.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : terminal requests/responses and database port (slave side)
module atm_db_scheduler
    import atm_pkg::*;
#(
    parameter int unsigned terminals_num = DefTerminalsNum,
    parameter int unsigned card_width    = DefCardWidth,
    parameter int unsigned balance_width = DefBalanceWidth,
    parameter int unsigned users_num     = DefUsersNum
) (
    input logic               clk,
    input logic               rst,
    atm_db_scheduler_if.slave bus
);

    localparam int unsigned ptr_w = idx_width(terminals_num);

    state_e                   state_q, state_d;
    logic [ptr_w-1:0]         ptr_q, win_idx;
    logic [terminals_num-1:0] arb_gnt, gnt_q, sel_q, rsp_valid_q;
    logic [card_width-1:0]    card_q;
    op_e                      op_q;
    logic [balance_width-1:0] value_q, rsp_balance_q, calc_bal;
    logic [balance_width:0]   sum;
    logic                     rsp_error_q, calc_err, calc_wr, card_ok, take, wr_en;

    rr_arbiter #(
        .n     (terminals_num),
        .ptr_w (ptr_w)
    ) u_rr_arbiter (
        .req     (bus.req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (win_idx)
    );

    // The RESP cycle arbitrates exactly like IDLE, so back-to-back grants
    // are three cycles apart instead of four.
    assign take = ((state_q == StIdle) || (state_q == StResp)) && (|bus.req);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (take) state_d = StRead;
            StRead:  state_d = StCalc;
            StCalc:  state_d = StResp;
            StResp:  state_d = take ? StRead : StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign card_ok = 32'(card_q) < users_num;

    always_comb begin
        sum      = {1'b0, bus.db_rdata} + {1'b0, value_q};
        calc_bal = bus.db_rdata;
        calc_err = 1'b0;
        calc_wr  = 1'b0;
        unique case (op_q)
            OpDeposit: begin
                if (sum[balance_width]) begin
                    calc_err = 1'b1;
                end else begin
                    calc_bal = sum[balance_width-1:0];
                    calc_wr  = 1'b1;
                end
            end
            OpWithdraw: begin
                if (value_q > bus.db_rdata) begin
                    calc_err = 1'b1;
                end else begin
                    calc_bal = bus.db_rdata - value_q;
                    calc_wr  = 1'b1;
                end
            end
            OpInquiry:  calc_err = 1'b0;
            OpReserved: calc_err = 1'b1;
        endcase
        // Unknown cards were never read; report zero and never write.
        if (!card_ok) begin
            calc_bal = '0;
            calc_err = 1'b1;
            calc_wr  = 1'b0;
        end
    end

    assign wr_en           = (state_q == StCalc) && calc_wr;
    assign bus.db_rd_en    = (state_q == StRead) && card_ok;
    assign bus.db_wr_en    = wr_en;
    assign bus.db_addr     = card_q;
    assign bus.db_wdata    = wr_en ? calc_bal : '0;
    assign bus.gnt         = gnt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_balance = rsp_balance_q;
    assign bus.rsp_error   = rsp_error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            gnt_q         <= '0;
            sel_q         <= '0;
            rsp_valid_q   <= '0;
            card_q        <= '0;
            op_q          <= OpDeposit;
            value_q       <= '0;
            rsp_balance_q <= '0;
            rsp_error_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= take ? arb_gnt : '0;
            rsp_valid_q <= (state_q == StCalc) ? sel_q : '0;
            if (take) begin
                sel_q   <= arb_gnt;
                card_q  <= bus.req_card[win_idx*card_width +: card_width];
                op_q    <= op_e'(bus.req_op[win_idx*2 +: 2]);
                value_q <= bus.req_value[win_idx*balance_width +: balance_width];
                ptr_q   <= (32'(win_idx) == terminals_num - 1) ? '0 : win_idx + 1'b1;
            end
            if (state_q == StCalc) begin
                rsp_balance_q <= calc_bal;
                rsp_error_q   <= calc_err;
            end
        end
    end

endmodule
